// File: rtl/seq_addsub_n.sv
// Chunk-serial adder/subtractor: CHUNK bits per clock, LS chunk first.
// Start/done handshake, carry/borrow chaining, signed overflow and zero flags.
module seq_addsub_n #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             mode,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NCH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             accept;
  logic             last;
  int               lo;
  logic [CHUNK-1:0] a_k;
  logic [CHUNK-1:0] b_k;
  logic [CHUNK-1:0] s_k;
  logic             c_k;
  logic [WIDTH-1:0] part_nx;

  assign accept = start && (state_q == S_IDLE || state_q == S_DONE);
  assign last   = (state_q == S_RUN) && (cnt_q == LAST_CNT);
  assign lo     = int'(cnt_q) * CHUNK;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN:  if (last)  state_d = S_DONE;
      S_DONE: state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // output logic
  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  // one chunk of ripple addition
  always_comb begin
    a_k = a_q[lo +: CHUNK];
    b_k = b_q[lo +: CHUNK];
    {c_k, s_k} = {1'b0, a_k} + {1'b0, b_k}
               + {{CHUNK{1'b0}}, carry_q};
    part_nx = part_q;
    part_nx[lo +: CHUNK] = s_k;
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    part_d  = part_q;
    if (accept) begin
      a_d     = x;
      b_d     = mode ? ~y : y;
      carry_d = mode ? ~cin : cin;
      cnt_d   = '0;
      part_d  = '0;
    end else if (state_q == S_RUN) begin
      part_d  = part_nx;
      carry_d = c_k;
      cnt_d   = last ? '0 : cnt_q + 1'b1;
    end
  end

  // result registers only move on the final chunk
  always_comb begin
    sum_d  = sum_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    zero_d = zero_q;
    if (last) begin
      sum_d  = part_nx;
      cout_d = c_k;
      ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1])
            && (part_nx[WIDTH-1] != a_q[WIDTH-1]);
      zero_d = (part_nx == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      part_q  <= part_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_seq_addsub_n.sv
// Directed bench for seq_addsub_n at 8/2, 16/4 and 8/8.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_seq_addsub_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start8, start16, start88;
  logic        mode, cin;
  logic [15:0] x, y;

  logic        busy8, done8, cout8, ovf8, zero8;
  logic [7:0]  sum8;
  logic        busy16, done16, cout16, ovf16, zero16;
  logic [15:0] sum16;
  logic        busy88, done88, cout88, ovf88, zero88;
  logic [7:0]  sum88;

  int tests = 0;
  int fails = 0;

  seq_addsub_n #(.WIDTH(8), .CHUNK(2)) u8 (
    .clk(clk), .rst(rst), .start(start8),
    .x(x[7:0]), .y(y[7:0]), .mode(mode), .cin(cin),
    .busy(busy8), .done(done8), .sum(sum8),
    .cout(cout8), .ovf(ovf8), .zero(zero8)
  );

  seq_addsub_n #(.WIDTH(16), .CHUNK(4)) u16 (
    .clk(clk), .rst(rst), .start(start16),
    .x(x), .y(y), .mode(mode), .cin(cin),
    .busy(busy16), .done(done16), .sum(sum16),
    .cout(cout16), .ovf(ovf16), .zero(zero16)
  );

  seq_addsub_n #(.WIDTH(8), .CHUNK(8)) u88 (
    .clk(clk), .rst(rst), .start(start88),
    .x(x[7:0]), .y(y[7:0]), .mode(mode), .cin(cin),
    .busy(busy88), .done(done88), .sum(sum88),
    .cout(cout88), .ovf(ovf88), .zero(zero88)
  );

  function automatic logic dn(input int sel);
    case (sel)
      0: return done8;
      1: return done16;
      default: return done88;
    endcase
  endfunction

  function automatic logic [18:0] outs(input int sel);
    case (sel)
      0: return {8'h00, sum8, cout8, ovf8, zero8};
      1: return {sum16, cout16, ovf16, zero16};
      default: return {8'h00, sum88, cout88, ovf88, zero88};
    endcase
  endfunction

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0: start8 = v;
      1: start16 = v;
      default: start88 = v;
    endcase
  endtask

  // one operation: pulse start, scramble inputs, wait (bounded) for done
  task automatic do_op(input int sel, input logic [15:0] a,
                       input logic [15:0] b, input logic m,
                       input logic c, output logic [18:0] r,
                       output int lat);
    @(negedge clk);
    x = a; y = b; mode = m; cin = c;
    set_start(sel, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_start(sel, 1'b0);
    x = 16'hDEAD; y = 16'hBEEF; mode = ~m; cin = ~c;
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (dn(sel)) begin
        lat = i;
        break;
      end
    end
    r = outs(sel);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start8 = 1'b0; start16 = 1'b0; start88 = 1'b0;
    x = '0; y = '0; mode = 1'b0; cin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({busy8, done8, sum8, cout8, ovf8, zero8} !== '0) begin
      fails++;
      $display("FAIL reset8: got %h want 0",
               {busy8, done8, sum8, cout8, ovf8, zero8});
    end
    tests++;
    if ({busy16, done16, sum16, cout16, ovf16, zero16} !== '0) begin
      fails++;
      $display("FAIL reset16: got %h want 0",
               {busy16, done16, sum16, cout16, ovf16, zero16});
    end
    tests++;
    if ({busy88, done88, sum88, cout88, ovf88, zero88} !== '0) begin
      fails++;
      $display("FAIL reset88: got %h want 0",
               {busy88, done88, sum88, cout88, ovf88, zero88});
    end
  endtask

  task automatic test_add;
    logic [18:0] r;
    int lat;
    do_op(0, 16'h0007, 16'h0002, 1'b0, 1'b0, r, lat);
    tests++;
    if (r !== {16'h0009, 3'b000}) begin
      fails++;
      $display("FAIL add: got %h want %h", r, {16'h0009, 3'b000});
    end
    tests++;
    if (lat !== 4) begin
      fails++;
      $display("FAIL add_latency: got %0d want 4", lat);
    end
  endtask

  task automatic test_sub;
    logic [18:0] r;
    int lat;
    do_op(0, 16'h0007, 16'h0002, 1'b1, 1'b0, r, lat);
    tests++;
    if (r !== {16'h0005, 3'b100}) begin
      fails++;
      $display("FAIL sub_pos: got %h want %h", r, {16'h0005, 3'b100});
    end
    do_op(0, 16'h0002, 16'h0007, 1'b1, 1'b0, r, lat);
    tests++;
    if (r !== {16'h00FB, 3'b000}) begin
      fails++;
      $display("FAIL sub_neg: got %h want %h", r, {16'h00FB, 3'b000});
    end
  endtask

  task automatic test_flags;
    logic [18:0] r;
    int lat;
    do_op(0, 16'h007F, 16'h0001, 1'b0, 1'b0, r, lat);
    tests++;
    if (r !== {16'h0080, 3'b010}) begin
      fails++;
      $display("FAIL ovf_add: got %h want %h", r, {16'h0080, 3'b010});
    end
    do_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, r, lat);
    tests++;
    if (r !== {16'h0000, 3'b101}) begin
      fails++;
      $display("FAIL carry_zero: got %h want %h", r, {16'h0000, 3'b101});
    end
    do_op(0, 16'h0080, 16'h0001, 1'b1, 1'b0, r, lat);
    tests++;
    if (r !== {16'h007F, 3'b110}) begin
      fails++;
      $display("FAIL ovf_sub: got %h want %h", r, {16'h007F, 3'b110});
    end
  endtask

  task automatic test_chain;
    logic [18:0] r;
    int lat;
    do_op(0, 16'h00FF, 16'h0000, 1'b0, 1'b1, r, lat);
    tests++;
    if (r !== {16'h0000, 3'b101}) begin
      fails++;
      $display("FAIL adc: got %h want %h", r, {16'h0000, 3'b101});
    end
    do_op(0, 16'h0010, 16'h0000, 1'b1, 1'b1, r, lat);
    tests++;
    if (r !== {16'h000F, 3'b100}) begin
      fails++;
      $display("FAIL sbc: got %h want %h", r, {16'h000F, 3'b100});
    end
  endtask

  // previous result is 0x0F; start pulsed mid-RUN must be ignored
  task automatic test_ignore_start;
    int nd;
    logic [7:0] got;
    @(negedge clk);
    x = 16'h0007; y = 16'h0002; mode = 1'b0; cin = 1'b0;
    start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b1;
    x = 16'h0050; y = 16'h0050;
    tests++;
    if ({busy8, done8, sum8} !== {1'b1, 1'b0, 8'h0F}) begin
      fails++;
      $display("FAIL run_hold: got %h want %h",
               {busy8, done8, sum8}, {1'b1, 1'b0, 8'h0F});
    end
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    nd = 0;
    got = 8'hXX;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done8) begin
        nd++;
        got = sum8;
      end
    end
    tests++;
    if (nd !== 1) begin
      fails++;
      $display("FAIL ignore_done_count: got %0d want 1", nd);
    end
    tests++;
    if (got !== 8'h09) begin
      fails++;
      $display("FAIL ignore_sum: got %h want 09", got);
    end
  endtask

  task automatic test_back_to_back;
    int lat1, lat2;
    @(negedge clk);
    x = 16'h0001; y = 16'h0001; mode = 1'b0; cin = 1'b0;
    start8 = 1'b1;
    @(posedge clk);
    lat1 = -1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done8) begin
        lat1 = i;
        break;
      end
    end
    tests++;
    if (lat1 !== 4 || sum8 !== 8'h02) begin
      fails++;
      $display("FAIL b2b_first: got lat %0d sum %h want 4 02",
               lat1, sum8);
    end
    x = 16'h0003; y = 16'h0004;
    lat2 = -1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done8) begin
        lat2 = i;
        break;
      end
    end
    start8 = 1'b0;
    tests++;
    if (lat2 !== 5 || sum8 !== 8'h07) begin
      fails++;
      $display("FAIL b2b_second: got lat %0d sum %h want 5 07",
               lat2, sum8);
    end
    @(posedge clk);
    @(negedge clk);
    tests++;
    if ({busy8, done8} !== 2'b00) begin
      fails++;
      $display("FAIL b2b_idle: got %b want 00", {busy8, done8});
    end
  endtask

  task automatic test_reset_mid_run;
    int nd;
    logic [18:0] r;
    int lat;
    @(negedge clk);
    x = 16'h0007; y = 16'h0002; mode = 1'b0; cin = 1'b0;
    start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({busy8, done8, sum8, cout8, ovf8, zero8} !== '0) begin
      fails++;
      $display("FAIL abort_outputs: got %h want 0",
               {busy8, done8, sum8, cout8, ovf8, zero8});
    end
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done8) nd++;
    end
    tests++;
    if (nd !== 0) begin
      fails++;
      $display("FAIL abort_done: got %0d pulses want 0", nd);
    end
    do_op(0, 16'h0007, 16'h0002, 1'b0, 1'b0, r, lat);
    tests++;
    if (r !== {16'h0009, 3'b000} || lat !== 4) begin
      fails++;
      $display("FAIL after_abort: got %h lat %0d want %h lat 4",
               r, lat, {16'h0009, 3'b000});
    end
  endtask

  task automatic test_w16_c4;
    logic [18:0] r;
    int lat;
    do_op(1, 16'h0007, 16'h0002, 1'b0, 1'b0, r, lat);
    tests++;
    if (r !== {16'h0009, 3'b000} || lat !== 4) begin
      fails++;
      $display("FAIL w16_add: got %h lat %0d want %h lat 4",
               r, lat, {16'h0009, 3'b000});
    end
    do_op(1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, r, lat);
    tests++;
    if (r !== {16'h8000, 3'b010}) begin
      fails++;
      $display("FAIL w16_ovf: got %h want %h", r, {16'h8000, 3'b010});
    end
    do_op(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, r, lat);
    tests++;
    if (r !== {16'h0000, 3'b101}) begin
      fails++;
      $display("FAIL w16_zero: got %h want %h", r, {16'h0000, 3'b101});
    end
  endtask

  task automatic test_w8_c8;
    logic [18:0] r;
    int lat;
    do_op(2, 16'h0007, 16'h0002, 1'b0, 1'b0, r, lat);
    tests++;
    if (r !== {16'h0009, 3'b000} || lat !== 1) begin
      fails++;
      $display("FAIL w8c8_add: got %h lat %0d want %h lat 1",
               r, lat, {16'h0009, 3'b000});
    end
    do_op(2, 16'h007F, 16'h0001, 1'b0, 1'b0, r, lat);
    tests++;
    if (r !== {16'h0080, 3'b010}) begin
      fails++;
      $display("FAIL w8c8_ovf: got %h want %h", r, {16'h0080, 3'b010});
    end
    do_op(2, 16'h00FF, 16'h0001, 1'b0, 1'b0, r, lat);
    tests++;
    if (r !== {16'h0000, 3'b101}) begin
      fails++;
      $display("FAIL w8c8_zero: got %h want %h", r, {16'h0000, 3'b101});
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_flags;
    test_chain;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid_run;
    test_w16_c4;
    test_w8_c8;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
